ifu_pcgen: RTL and testbench

//  IF0 next-fetch-PC generator. Owns the IF1 fetch PC register that drives the BTB lookup.

---
 rtl/pcgen_pkg.sv | 32 +++
 rtl/ifu_ras.sv | 96 +++++++++
 rtl/ifu_pcgen.sv | 172 +++++++++++++++++
 tb/tb_ifu_pcgen.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcgen_pkg.sv
// pcgen_pkg: shared types and constants for the IF0 next-PC generator.
// Provides branch type enum, fetch geometry, IF2 metadata bundle, seq-PC helper.
package pcgen_pkg;

    typedef enum logic [1:0] {
        BT_COND = 2'b00,
        BT_CALL = 2'b01,
        BT_JUMP = 2'b10,
        BT_RET  = 2'b11
    } btype_t;

    localparam int unsigned FETCH_BYTES      = 8;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned DEF_RAS_DEPTH    = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        pred_idx;
        logic        btb_way;
        logic [1:0]  bm_pred;
        btype_t      btype;
    } if2_meta_t;

    // Next aligned fetch group; wraps at the top of the address space.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return (pc & ~32'(FETCH_BYTES - 1)) + 32'(FETCH_BYTES);
    endfunction

endpackage

// File: rtl/ifu_ras.sv
// ifu_ras: return address stack with speculative and committed copies.
// Ports: spec push/pop, commit push/pop, restore (spec <= committed), TOS/nonempty out.
module ifu_ras
    import pcgen_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
    input  logic        cpu_clk_i,
    input  logic        reset_ni,
    input  logic        spec_push_i,
    input  logic [31:0] spec_push_addr_i,
    input  logic        spec_pop_i,
    input  logic        restore_i,
    input  logic        commit_push_i,
    input  logic        commit_pop_i,
    input  logic [31:0] commit_push_addr_i,
    output logic [31:0] tos_o,
    output logic        nonempty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   s_stk [DEPTH];
    logic [31:0]   c_stk [DEPTH];
    logic [31:0]   c_stk_n [DEPTH];
    logic [PW-1:0] s_ptr;
    logic [PW-1:0] c_ptr;
    logic [PW-1:0] c_ptr_n;
    logic [CW-1:0] s_cnt;
    logic [CW-1:0] c_cnt;
    logic [CW-1:0] c_cnt_n;
    logic          do_cpush;
    logic          do_cpop;

    // ptr addresses the next free slot; TOS sits just below it.
    assign tos_o      = s_stk[s_ptr - PW'(1)];
    assign nonempty_o = (s_cnt != '0);

    // Call and ret retiring together cancel; ret on empty is dropped.
    assign do_cpush = commit_push_i & ~commit_pop_i;
    assign do_cpop  = commit_pop_i & ~commit_push_i & (c_cnt != '0);

    always_comb begin
        c_stk_n = c_stk;
        c_ptr_n = c_ptr;
        c_cnt_n = c_cnt;
        unique case (1'b1)
            do_cpush: begin
                c_stk_n[c_ptr] = commit_push_addr_i;
                c_ptr_n        = c_ptr + PW'(1);
                if (c_cnt != FULL)
                    c_cnt_n = c_cnt + CW'(1);
            end
            do_cpop: begin
                c_ptr_n = c_ptr - PW'(1);
                c_cnt_n = c_cnt - CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_stk[i] <= '0;
                c_stk[i] <= '0;
            end
            s_ptr <= '0;
            s_cnt <= '0;
            c_ptr <= '0;
            c_cnt <= '0;
        end else begin
            c_stk <= c_stk_n;
            c_ptr <= c_ptr_n;
            c_cnt <= c_cnt_n;
            if (restore_i) begin
                // Restore sees this cycle's retirement as well.
                s_stk <= c_stk_n;
                s_ptr <= c_ptr_n;
                s_cnt <= c_cnt_n;
            end else if (spec_push_i) begin
                // Full stack overwrites the oldest entry.
                s_stk[s_ptr] <= spec_push_addr_i;
                s_ptr        <= s_ptr + PW'(1);
                if (s_cnt != FULL)
                    s_cnt <= s_cnt + CW'(1);
            end else if (spec_pop_i && s_cnt != '0) begin
                s_ptr <= s_ptr - PW'(1);
                s_cnt <= s_cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ifu_pcgen.sv
// ifu_pcgen: IF0 next-fetch-PC generator; owns IF1 PC, registers IF2 prediction metadata.
// In: BTB lookup, dec/commit redirects, stall, commit call/ret. Out: IF1 PC/valid, IF2 meta. Opt: PCGEN_RAS_EN.
module ifu_pcgen
    import pcgen_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int unsigned RAS_DEPTH    = DEF_RAS_DEPTH
) (
    input  logic        cpu_clk_i,
    input  logic        reset_ni,
    input  logic        if1_stall_i,
    input  logic        btb_vld_i,
    input  logic [1:0]  btb_btype_i,
    input  logic [1:0]  btb_bm_pred_i,
    input  logic [31:0] btb_target_i,
    input  logic        btb_index_i,
    input  logic        btb_way_present_i,
    input  logic        dec_redirect_i,
    input  logic [31:0] dec_redirect_pc_i,
    input  logic        c1_redirect_i,
    input  logic [31:0] c1_redirect_pc_i,
    input  logic        c1_call_commit_i,
    input  logic        c1_ret_commit_i,
    input  logic [31:0] c1_call_ret_addr_i,
    output logic [31:0] if1_current_pc_o,
    output logic        if1_valid_o,
    output logic        if2_valid_o,
    output logic [31:0] if2_pc_o,
    output logic        if2_pred_taken_o,
    output logic [31:0] if2_pred_target_o,
    output logic        if2_pred_idx_o,
    output logic        if2_btb_way_o,
    output logic [1:0]  if2_bm_pred_o,
    output logic [1:0]  if2_btype_o
);

    btype_t      btype;
    logic        redirect;
    logic        taken;
    logic [31:0] seq_pc;
    logic [31:0] br_target;
    logic [31:0] pred_target;
    logic [31:0] pc_q;
    logic [31:0] pc_n;
    logic        if1_valid_q;
    logic        if1_valid_n;
    if2_meta_t   if2_q;
    if2_meta_t   if2_n;
    logic        if2_ld;
    logic        sel_c1;
    logic        sel_dec;
    logic        sel_hold;
    logic        sel_pred;

    assign btype    = btype_t'(btb_btype_i);
    assign redirect = c1_redirect_i | dec_redirect_i;
    assign taken    = btb_vld_i & ((btype != BT_COND) | btb_bm_pred_i[1]);
    assign seq_pc   = next_seq_pc(pc_q);

`ifdef PCGEN_RAS_EN
    logic        advance;
    logic        ret_from_ras;
    logic        ras_push;
    logic        ras_pop;
    logic        ras_nonempty;
    logic [31:0] ras_tos;
    logic [31:0] ras_push_addr;

    assign advance       = if1_valid_q & ~if1_stall_i & ~redirect;
    assign ret_from_ras  = taken & (btype == BT_RET) & ras_nonempty;
    assign ras_push      = advance & taken & (btype == BT_CALL);
    assign ras_pop       = advance & ret_from_ras;
    // Return lands after the 4-byte call in its slot.
    assign ras_push_addr = {pc_q[31:3], btb_index_i, 2'b00} + 32'd4;
    assign br_target     = ret_from_ras ? ras_tos : btb_target_i;

    ifu_ras #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .cpu_clk_i         (cpu_clk_i),
        .reset_ni          (reset_ni),
        .spec_push_i       (ras_push),
        .spec_push_addr_i  (ras_push_addr),
        .spec_pop_i        (ras_pop),
        .restore_i         (c1_redirect_i),
        .commit_push_i     (c1_call_commit_i),
        .commit_pop_i      (c1_ret_commit_i),
        .commit_push_addr_i(c1_call_ret_addr_i),
        .tos_o             (ras_tos),
        .nonempty_o        (ras_nonempty)
    );
`else
    logic [33:0] unused_ras;
    logic [31:0] unused_depth;

    assign unused_ras   = {c1_call_commit_i, c1_ret_commit_i, c1_call_ret_addr_i};
    assign unused_depth = RAS_DEPTH;
    assign br_target    = btb_target_i;
`endif

    assign pred_target = taken ? br_target : seq_pc;

    // One-hot next-PC select; an invalid IF1 slot (just out of reset) holds.
    assign sel_c1   = c1_redirect_i;
    assign sel_dec  = dec_redirect_i & ~c1_redirect_i;
    assign sel_hold = ~redirect & (if1_stall_i | ~if1_valid_q);
    assign sel_pred = ~redirect & ~if1_stall_i & if1_valid_q;

    always_comb begin
        pc_n        = pc_q;
        if1_valid_n = if1_valid_q;
        unique case (1'b1)
            sel_c1: begin
                pc_n        = c1_redirect_pc_i;
                if1_valid_n = 1'b1;
            end
            sel_dec: begin
                pc_n        = dec_redirect_pc_i;
                if1_valid_n = 1'b1;
            end
            sel_hold: begin
                pc_n        = pc_q;
                if1_valid_n = if1_valid_q | ~if1_stall_i;
            end
            sel_pred: begin
                pc_n        = pred_target;
                if1_valid_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        if2_n             = if2_q;
        if2_n.valid       = if1_valid_q & ~redirect;
        if2_n.pc          = pc_q;
        if2_n.pred_taken  = taken;
        if2_n.pred_target = pred_target;
        if2_n.pred_idx    = taken ? btb_index_i : 1'b1;
        if2_n.btb_way     = btb_way_present_i;
        if2_n.bm_pred     = btb_bm_pred_i;
        if2_n.btype       = btype;
    end

    // A redirect squashes IF2 even while stalled.
    assign if2_ld = ~if1_stall_i | redirect;

    always_ff @(posedge cpu_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pc_q        <= RESET_VECTOR;
            if1_valid_q <= 1'b0;
            if2_q       <= '0;
        end else begin
            pc_q        <= pc_n;
            if1_valid_q <= if1_valid_n;
            if (if2_ld)
                if2_q <= if2_n;
        end
    end

    assign if1_current_pc_o  = pc_q;
    assign if1_valid_o       = if1_valid_q;
    assign if2_valid_o       = if2_q.valid;
    assign if2_pc_o          = if2_q.pc;
    assign if2_pred_taken_o  = if2_q.pred_taken;
    assign if2_pred_target_o = if2_q.pred_target;
    assign if2_pred_idx_o    = if2_q.pred_idx;
    assign if2_btb_way_o     = if2_q.btb_way;
    assign if2_bm_pred_o     = if2_q.bm_pred;
    assign if2_btype_o       = if2_q.btype;

endmodule

// File: tb/tb_ifu_pcgen.sv
// tb_ifu_pcgen: scoreboard bench for ifu_pcgen (RAS scenarios with PCGEN_RAS_EN).
// Expected IF1/IF2 snapshots are queued with each stimulus row and popped after the edge.
module tb_ifu_pcgen;

    typedef struct packed {
        logic [31:0] pc;
        logic        v1;
        logic        v2;
        logic [31:0] ipc;
        logic        tk;
        logic [31:0] tgt;
        logic        idx;
        logic        way;
        logic [1:0]  bm;
        logic [1:0]  bt;
    } obs_t;

    typedef struct packed {
        logic        c1;
        logic [31:0] c1pc;
        logic        dec;
        logic [31:0] decpc;
        logic        stall;
        logic        vld;
        logic [1:0]  bt;
        logic [1:0]  bm;
        logic [31:0] tgt;
        logic        idx;
        logic        way;
        logic        ccall;
        logic        cret;
        logic [31:0] caddr;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, vld, idx, way, dec, c1, ccall, cret;
    logic [1:0]  bt, bm;
    logic [31:0] tgt, decpc, c1pc, caddr;
    logic [31:0] pc_o, if2_pc, if2_tgt;
    logic        v1_o, v2_o, tk_o, idx_o, way_o;
    logic [1:0]  bm_o, bt_o;

    int   total = 0;
    int   bad = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    ifu_pcgen dut (
        .cpu_clk_i         (clk),
        .reset_ni          (rst_n),
        .if1_stall_i       (stall),
        .btb_vld_i         (vld),
        .btb_btype_i       (bt),
        .btb_bm_pred_i     (bm),
        .btb_target_i      (tgt),
        .btb_index_i       (idx),
        .btb_way_present_i (way),
        .dec_redirect_i    (dec),
        .dec_redirect_pc_i (decpc),
        .c1_redirect_i     (c1),
        .c1_redirect_pc_i  (c1pc),
        .c1_call_commit_i  (ccall),
        .c1_ret_commit_i   (cret),
        .c1_call_ret_addr_i(caddr),
        .if1_current_pc_o  (pc_o),
        .if1_valid_o       (v1_o),
        .if2_valid_o       (v2_o),
        .if2_pc_o          (if2_pc),
        .if2_pred_taken_o  (tk_o),
        .if2_pred_target_o (if2_tgt),
        .if2_pred_idx_o    (idx_o),
        .if2_btb_way_o     (way_o),
        .if2_bm_pred_o     (bm_o),
        .if2_btype_o       (bt_o)
    );

    function automatic logic [31:0] seqa(input logic [31:0] p);
        return (p & 32'hFFFF_FFF8) + 32'd8;
    endfunction

    function automatic obs_t ex(input logic [31:0] pc, input logic v2,
                                input logic [31:0] ipc, input logic tk,
                                input logic [31:0] t, input logic i,
                                input logic w, input logic [1:0] b,
                                input logic [1:0] ty);
        obs_t o;
        o.pc = pc; o.v1 = 1'b1; o.v2 = v2; o.ipc = ipc; o.tk = tk;
        o.tgt = t; o.idx = i; o.way = w; o.bm = b; o.bt = ty;
        return o;
    endfunction

    function automatic obs_t nt(input logic [31:0] pc, input logic v2,
                                input logic [31:0] ipc);
        return ex(pc, v2, ipc, 1'b0, seqa(ipc), 1'b1, 1'b0, 2'b00, 2'b00);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t hit(input logic [1:0] ty, input logic [1:0] b,
                                  input logic [31:0] t, input logic i,
                                  input logic w);
        stim_t s;
        s = '0;
        s.vld = 1'b1; s.bt = ty; s.bm = b; s.tgt = t; s.idx = i; s.way = w;
        return s;
    endfunction

    function automatic stim_t decr(input logic [31:0] p);
        stim_t s;
        s = '0;
        s.dec = 1'b1; s.decpc = p;
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pc = pc_o; o.v1 = v1_o; o.v2 = v2_o; o.ipc = if2_pc; o.tk = tk_o;
        o.tgt = if2_tgt; o.idx = idx_o; o.way = way_o; o.bm = bm_o; o.bt = bt_o;
        return o;
    endfunction

    task automatic drive(input stim_t s);
        c1 = s.c1; c1pc = s.c1pc; dec = s.dec; decpc = s.decpc;
        stall = s.stall; vld = s.vld; bt = s.bt; bm = s.bm; tgt = s.tgt;
        idx = s.idx; way = s.way; ccall = s.ccall; cret = s.cret; caddr = s.caddr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        drive(idle());
        repeat (3) tick();
        exp_q.push_back('0);
        got = sample();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset got=%h want=%h", got, want);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_seq();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(idle()); e.push_back(nt(32'h0, 1'b0, 32'h0));
        s.push_back(idle()); e.push_back(nt(32'h8, 1'b1, 32'h0));
        s.push_back(idle()); e.push_back(nt(32'h10, 1'b1, 32'h8));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL seq[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_predict();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(decr(32'h100));
        e.push_back(nt(32'h100, 1'b0, 32'h10));
        s.push_back(hit(2'b00, 2'b01, 32'h400, 1'b0, 1'b1));
        e.push_back(ex(32'h108, 1'b1, 32'h100, 1'b0, 32'h108, 1'b1, 1'b1, 2'b01, 2'b00));
        s.push_back(hit(2'b00, 2'b10, 32'h400, 1'b1, 1'b0));
        e.push_back(ex(32'h400, 1'b1, 32'h108, 1'b1, 32'h400, 1'b1, 1'b0, 2'b10, 2'b00));
        s.push_back(hit(2'b10, 2'b00, 32'h2000_0004, 1'b0, 1'b1));
        e.push_back(ex(32'h2000_0004, 1'b1, 32'h400, 1'b1, 32'h2000_0004, 1'b0, 1'b1, 2'b00, 2'b10));
        s.push_back(idle());
        e.push_back(nt(32'h2000_0008, 1'b1, 32'h2000_0004));
        s.push_back(hit(2'b11, 2'b00, 32'h500, 1'b0, 1'b0));
        e.push_back(ex(32'h500, 1'b1, 32'h2000_0008, 1'b1, 32'h500, 1'b0, 1'b0, 2'b00, 2'b11));
        s.push_back(hit(2'b00, 2'b11, 32'h600, 1'b0, 1'b0));
        e.push_back(ex(32'h600, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 1'b0, 2'b11, 2'b00));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL predict[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(decr(32'hFFFF_FFF8)); e.push_back(nt(32'hFFFF_FFF8, 1'b0, 32'h600));
        s.push_back(idle());              e.push_back(nt(32'h0, 1'b1, 32'hFFFF_FFF8));
        s.push_back(decr(32'hFFFF_FFFC)); e.push_back(nt(32'hFFFF_FFFC, 1'b0, 32'h0));
        s.push_back(idle());              e.push_back(nt(32'h0, 1'b1, 32'hFFFF_FFFC));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL wrap[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_priority();
        stim_t s[$];
        obs_t  e[$];
        stim_t r;
        obs_t  got, want;
        r = decr(32'h3000); r.c1 = 1'b1; r.c1pc = 32'h2004; r.stall = 1'b1;
        s.push_back(r); e.push_back(nt(32'h2004, 1'b0, 32'h0));
        r = decr(32'h3000); r.stall = 1'b1;
        s.push_back(r); e.push_back(nt(32'h3000, 1'b0, 32'h2004));
        s.push_back(idle()); e.push_back(nt(32'h3008, 1'b1, 32'h3000));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL priority[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_stall();
        stim_t s[$];
        obs_t  e[$];
        stim_t r;
        obs_t  got, want;
        s.push_back(decr(32'h40)); e.push_back(nt(32'h40, 1'b0, 32'h3008));
        r = hit(2'b10, 2'b11, 32'h7000, 1'b1, 1'b1);
        r.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s.push_back(r); e.push_back(nt(32'h40, 1'b0, 32'h3008));
        end
        s.push_back(hit(2'b10, 2'b11, 32'h7000, 1'b1, 1'b1));
        e.push_back(ex(32'h7000, 1'b1, 32'h40, 1'b1, 32'h7000, 1'b1, 1'b1, 2'b11, 2'b10));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL stall[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

`ifdef PCGEN_RAS_EN
    task automatic test_ras_call_ret();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(decr(32'h1004)); e.push_back(nt(32'h1004, 1'b0, 32'h7000));
        s.push_back(hit(2'b01, 2'b00, 32'h8000, 1'b1, 1'b0));
        e.push_back(ex(32'h8000, 1'b1, 32'h1004, 1'b1, 32'h8000, 1'b1, 1'b0, 2'b00, 2'b01));
        s.push_back(hit(2'b11, 2'b00, 32'h9999_0000, 1'b0, 1'b0));
        e.push_back(ex(32'h1008, 1'b1, 32'h8000, 1'b1, 32'h1008, 1'b0, 1'b0, 2'b00, 2'b11));
        s.push_back(hit(2'b11, 2'b00, 32'h9999_0000, 1'b0, 1'b0));
        e.push_back(ex(32'h9999_0000, 1'b1, 32'h1008, 1'b1, 32'h9999_0000, 1'b0, 1'b0, 2'b00, 2'b11));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL ras_call_ret[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_ras_restore();
        stim_t s[$];
        obs_t  e[$];
        stim_t r;
        obs_t  frz;
        obs_t  got, want;
        logic [31:0] p;
        logic [31:0] rets [3];
        frz = ex(32'h9999_0000, 1'b1, 32'h1008, 1'b1, 32'h9999_0000, 1'b0, 1'b0, 2'b00, 2'b11);
        r = idle(); r.stall = 1'b1; r.ccall = 1'b1; r.caddr = 32'hA0;
        s.push_back(r); e.push_back(frz);
        r.caddr = 32'hB0;
        s.push_back(r); e.push_back(frz);
        s.push_back(decr(32'h1_0000)); e.push_back(nt(32'h1_0000, 1'b0, 32'h9999_0000));
        for (int k = 0; k < 9; k++) begin
            p = 32'h1_0000 + 32'(k) * 32'h100;
            s.push_back(hit(2'b01, 2'b00, p + 32'h100, 1'b0, 1'b0));
            e.push_back(ex(p + 32'h100, 1'b1, p, 1'b1, p + 32'h100, 1'b0, 1'b0, 2'b00, 2'b01));
        end
        r = idle(); r.c1 = 1'b1; r.c1pc = 32'h5_0000; r.ccall = 1'b1; r.caddr = 32'hC0;
        s.push_back(r); e.push_back(nt(32'h5_0000, 1'b0, 32'h1_0900));
        rets[0] = 32'hC0; rets[1] = 32'hB0; rets[2] = 32'hA0;
        p = 32'h5_0000;
        for (int k = 0; k < 3; k++) begin
            s.push_back(hit(2'b11, 2'b00, 32'hDEAD_0000, 1'b0, 1'b0));
            e.push_back(ex(rets[k], 1'b1, p, 1'b1, rets[k], 1'b0, 1'b0, 2'b00, 2'b11));
            p = rets[k];
        end
        s.push_back(hit(2'b11, 2'b00, 32'hDEAD_0000, 1'b0, 1'b0));
        e.push_back(ex(32'hDEAD_0000, 1'b1, 32'hA0, 1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 2'b00, 2'b11));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL ras_restore[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask
`endif

    task automatic test_async_reset();
        obs_t got, want;
        drive(idle());
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.push_back('0);
        got = sample();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", got, want);
        end
        tick();
        rst_n = 1'b1;
        exp_q.push_back(nt(32'h0, 1'b0, 32'h0));
        tick();
        got = sample();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", got, want);
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_predict();
        test_wrap();
        test_priority();
        test_stall();
`ifdef PCGEN_RAS_EN
        test_ras_call_ret();
        test_ras_restore();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
